// File: rtl/slb.sv
// Store/load buffer: in-order memory op queue between dispatch, ROB and memory controller.
// Optional macro SLB_STAT_EN adds completed load/store counters (oSTAT_LD, oSTAT_ST).

`ifndef OpBus
`define OpBus 3:0
`endif
`ifndef NickBus
`define NickBus 4:0
`endif

// Op encoding: bit3 = store, bit2 = zero-extend, bits[1:0] = size (0 byte, 1 half, 2 word).
//   LB=0000 LH=0001 LW=0010 LBU=0100 LHU=0101 SB=1000 SH=1001 SW=1010
module slb #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             iCLR,
  output logic             oFULL,
  input  logic             iDP_en,
  input  logic [`OpBus]    iDP_op,
  input  logic [`NickBus]  iDP_nick,
  input  logic [31:0]      iDP_imm,
  input  logic [`NickBus]  iDP_rs1_nick,
  input  logic [`NickBus]  iDP_rs2_nick,
  input  logic [31:0]      iDP_rs1_dt,
  input  logic [31:0]      iDP_rs2_dt,
  input  logic             iEX_en,
  input  logic [`NickBus]  iEX_nick,
  input  logic [31:0]      iEX_dt,
  input  logic             iROB_store_en,
  input  logic [`NickBus]  iROB_store_nick,
  output logic             oROB_en,
  output logic [`NickBus]  oROB_nick,
  output logic [31:0]      oROB_dt,
  output logic             oMC_en,
  output logic             oMC_wr,
  output logic [31:0]      oMC_addr,
  output logic [1:0]       oMC_len,
  output logic [31:0]      oMC_dt,
  input  logic             iMC_done,
  input  logic [31:0]      iMC_dt
`ifdef SLB_STAT_EN
  ,
  output logic [31:0]      oSTAT_LD,
  output logic [31:0]      oSTAT_ST
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  localparam logic [PTR_W:0] FULL_MARK = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] CNT_MAX   = (PTR_W+1)'(DEPTH);

  state_t state, state_next;

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic [DEPTH-1:0] valid, committed;

  logic [`OpBus]   op_q       [DEPTH];
  logic [`NickBus] nick_q     [DEPTH];
  logic [31:0]     imm_q      [DEPTH];
  logic [`NickBus] rs1_nick_q [DEPTH];
  logic [`NickBus] rs2_nick_q [DEPTH];
  logic [31:0]     rs1_dt_q   [DEPTH];
  logic [31:0]     rs2_dt_q   [DEPTH];

  logic [`OpBus] mc_op;
  logic          rob_ld;
  logic          rob_fwd;

  logic            enq, issue, pop, emit, mc_clear, hd_ready;
  logic [DEPTH-1:0] cmt_next;
  logic [PTR_W:0]   ncommit;

  logic [`NickBus] dp_rs1_nick, dp_rs2_nick;
  logic [31:0]     dp_rs1_dt, dp_rs2_dt;

  assign oFULL   = (count >= FULL_MARK);
  assign rob_fwd = oROB_en && rob_ld;
  assign enq     = rdy && iDP_en && !iCLR && (count != CNT_MAX);

  function automatic logic [31:0] extend(input logic [`OpBus] op, input logic [31:0] raw);
    case (op[1:0])
      2'd0:    return op[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    return op[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Dispatch-cycle operand capture from the ALU CDB or our own load result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dp_rs1_nick = iDP_rs1_nick;
    dp_rs1_dt   = iDP_rs1_dt;
    dp_rs2_nick = iDP_rs2_nick;
    dp_rs2_dt   = iDP_rs2_dt;
    if (iDP_rs1_nick != '0) begin
      if (iEX_en && iDP_rs1_nick == iEX_nick) begin
        dp_rs1_nick = '0;
        dp_rs1_dt   = iEX_dt;
      end else if (rob_fwd && iDP_rs1_nick == oROB_nick) begin
        dp_rs1_nick = '0;
        dp_rs1_dt   = oROB_dt;
      end
    end
    if (iDP_rs2_nick != '0) begin
      if (iEX_en && iDP_rs2_nick == iEX_nick) begin
        dp_rs2_nick = '0;
        dp_rs2_dt   = iEX_dt;
      end else if (rob_fwd && iDP_rs2_nick == oROB_nick) begin
        dp_rs2_nick = '0;
        dp_rs2_dt   = oROB_dt;
      end
    end
  end

  // Commit marks for this cycle and the surviving (committed) prefix length on flush.
  always_comb begin
    cmt_next = committed;
    ncommit  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (iROB_store_en && valid[i] && nick_q[i] == iROB_store_nick)
        cmt_next[i] = 1'b1;
      ncommit = ncommit + (PTR_W+1)'(valid[i] && cmt_next[i]);
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    pop        = 1'b0;
    emit       = 1'b0;
    mc_clear   = 1'b0;
    hd_ready   = valid[head] && (rs1_nick_q[head] == '0) &&
                 (!op_q[head][3] || ((rs2_nick_q[head] == '0) && committed[head]));
    if (rdy) begin
      case (state)
        IDLE: begin
          if (hd_ready && !(iCLR && !committed[head])) begin
            issue      = 1'b1;
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (iMC_done) begin
            mc_clear   = 1'b1;
            state_next = IDLE;
            if (!(iCLR && !oMC_wr)) begin
              pop  = 1'b1;
              emit = 1'b1;
            end
          end else if (iCLR && !oMC_wr) begin
            state_next = DISCARD;
          end
        end
        DISCARD: begin
          if (iMC_done) begin
            mc_clear   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      valid     <= '0;
      committed <= '0;
      oMC_en    <= 1'b0;
      oMC_wr    <= 1'b0;
      oMC_addr  <= '0;
      oMC_len   <= '0;
      oMC_dt    <= '0;
      mc_op     <= '0;
      oROB_en   <= 1'b0;
      oROB_nick <= '0;
      oROB_dt   <= '0;
      rob_ld    <= 1'b0;
`ifdef SLB_STAT_EN
      oSTAT_LD  <= '0;
      oSTAT_ST  <= '0;
`endif
    end else begin
      oROB_en <= 1'b0;
      if (rdy) begin
        for (int i = 0; i < DEPTH; i++) begin
          committed[i] <= cmt_next[i];
          if (iCLR && !cmt_next[i]) valid[i] <= 1'b0;
        end
        if (pop) begin
          valid[head]     <= 1'b0;
          committed[head] <= 1'b0;
          head            <= head + 1'b1;
        end
        if (enq) begin
          valid[tail]     <= 1'b1;
          committed[tail] <= 1'b0;
        end

        if (iCLR) begin
          tail  <= head + ncommit[PTR_W-1:0];
          count <= ncommit - (PTR_W+1)'(pop);
        end else begin
          tail  <= tail + PTR_W'(enq);
          count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
        end

        if (issue) begin
          oMC_en   <= 1'b1;
          oMC_wr   <= op_q[head][3];
          oMC_addr <= rs1_dt_q[head] + imm_q[head];
          oMC_len  <= op_q[head][1:0];
          oMC_dt   <= op_q[head][3] ? rs2_dt_q[head] : 32'd0;
          mc_op    <= op_q[head];
        end
        if (mc_clear) oMC_en <= 1'b0;

        if (emit) begin
          oROB_en   <= 1'b1;
          oROB_nick <= nick_q[head];
          oROB_dt   <= oMC_wr ? 32'd0 : extend(mc_op, iMC_dt);
          rob_ld    <= !oMC_wr;
`ifdef SLB_STAT_EN
          if (oMC_wr) oSTAT_ST <= oSTAT_ST + 32'd1;
          else        oSTAT_LD <= oSTAT_LD + 32'd1;
`endif
        end
      end
    end
  end

  // NOTE: payload arrays carry no reset; the valid flags gate every use of their contents.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i]) begin
          if (rs1_nick_q[i] != '0) begin
            if (iEX_en && rs1_nick_q[i] == iEX_nick) begin
              rs1_nick_q[i] <= '0;
              rs1_dt_q[i]   <= iEX_dt;
            end else if (rob_fwd && rs1_nick_q[i] == oROB_nick) begin
              rs1_nick_q[i] <= '0;
              rs1_dt_q[i]   <= oROB_dt;
            end
          end
          if (rs2_nick_q[i] != '0) begin
            if (iEX_en && rs2_nick_q[i] == iEX_nick) begin
              rs2_nick_q[i] <= '0;
              rs2_dt_q[i]   <= iEX_dt;
            end else if (rob_fwd && rs2_nick_q[i] == oROB_nick) begin
              rs2_nick_q[i] <= '0;
              rs2_dt_q[i]   <= oROB_dt;
            end
          end
        end
      end
      if (enq) begin
        op_q[tail]       <= iDP_op;
        nick_q[tail]     <= iDP_nick;
        imm_q[tail]      <= iDP_imm;
        rs1_nick_q[tail] <= dp_rs1_nick;
        rs1_dt_q[tail]   <= dp_rs1_dt;
        rs2_nick_q[tail] <= dp_rs2_nick;
        rs2_dt_q[tail]   <= dp_rs2_dt;
      end
    end
  end

endmodule

// File: tb/tb_slb.sv
// Directed self-checking bench for slb: load table, store commit, flush/discard, fill/wrap, async reset.
module tb_slb;

  localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010, LBU = 4'b0100,
                         LHU = 4'b0101, SB = 4'b1000, SW = 4'b1010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        iCLR = 1'b0;
  logic        oFULL;
  logic        iDP_en = 1'b0;
  logic [3:0]  iDP_op = '0;
  logic [4:0]  iDP_nick = '0, iDP_rs1_nick = '0, iDP_rs2_nick = '0;
  logic [31:0] iDP_imm = '0, iDP_rs1_dt = '0, iDP_rs2_dt = '0;
  logic        iEX_en = 1'b0;
  logic [4:0]  iEX_nick = '0;
  logic [31:0] iEX_dt = '0;
  logic        iROB_store_en = 1'b0;
  logic [4:0]  iROB_store_nick = '0;
  logic        oROB_en;
  logic [4:0]  oROB_nick;
  logic [31:0] oROB_dt;
  logic        oMC_en, oMC_wr;
  logic [31:0] oMC_addr, oMC_dt;
  logic [1:0]  oMC_len;
  logic        iMC_done = 1'b0;
  logic [31:0] iMC_dt = '0;
`ifdef SLB_STAT_EN
  logic [31:0] oSTAT_LD, oSTAT_ST;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  slb dut (
    .clk(clk), .rst(rst), .rdy(rdy), .iCLR(iCLR), .oFULL(oFULL),
    .iDP_en(iDP_en), .iDP_op(iDP_op), .iDP_nick(iDP_nick), .iDP_imm(iDP_imm),
    .iDP_rs1_nick(iDP_rs1_nick), .iDP_rs2_nick(iDP_rs2_nick),
    .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs2_dt(iDP_rs2_dt),
    .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
    .iROB_store_en(iROB_store_en), .iROB_store_nick(iROB_store_nick),
    .oROB_en(oROB_en), .oROB_nick(oROB_nick), .oROB_dt(oROB_dt),
    .oMC_en(oMC_en), .oMC_wr(oMC_wr), .oMC_addr(oMC_addr), .oMC_len(oMC_len),
    .oMC_dt(oMC_dt), .iMC_done(iMC_done), .iMC_dt(iMC_dt)
`ifdef SLB_STAT_EN
    , .oSTAT_LD(oSTAT_LD), .oSTAT_ST(oSTAT_ST)
`endif
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] raw;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] dt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic dispatch(input logic [3:0] op, input logic [4:0] nick, input logic [31:0] imm,
                          input logic [4:0] n1, input logic [31:0] d1,
                          input logic [4:0] n2, input logic [31:0] d2);
    iDP_en = 1'b1; iDP_op = op; iDP_nick = nick; iDP_imm = imm;
    iDP_rs1_nick = n1; iDP_rs1_dt = d1; iDP_rs2_nick = n2; iDP_rs2_dt = d2;
    @(negedge clk);
    iDP_en = 1'b0;
  endtask

  task automatic wait_mc(input string name);
    for (int i = 0; i < 20; i++) begin
      if (oMC_en) break;
      @(negedge clk);
    end
    check({name, " mc_en"}, {31'd0, oMC_en}, 32'd1);
  endtask

  task automatic mc_done(input logic [31:0] raw, input int delay);
    repeat (delay) @(negedge clk);
    iMC_done = 1'b1; iMC_dt = raw;
    @(negedge clk);
    iMC_done = 1'b0;
  endtask

  task automatic service(input string name, input logic [31:0] raw, input int delay,
                         input logic [4:0] nick, input logic [31:0] dt);
    mc_done(raw, delay);
    for (int i = 0; i < 20; i++) begin
      if (oROB_en) break;
      @(negedge clk);
    end
    check({name, " rob_en"}, {31'd0, oROB_en}, 32'd1);
    check({name, " rob_nick"}, {27'd0, oROB_nick}, {27'd0, nick});
    check({name, " rob_dt"}, oROB_dt, dt);
    @(negedge clk);
    check({name, " rob_pulse"}, {31'd0, oROB_en}, 32'd0);
  endtask

  // Counts cycles with oROB_en / oMC_en high over a window.
  task automatic quiet(input string name, input int cycles, input bit want_mc_idle);
    int robs = 0, mcs = 0;
    for (int i = 0; i < cycles; i++) begin
      if (oROB_en) robs++;
      if (oMC_en) mcs++;
      @(negedge clk);
    end
    check({name, " no_rob"}, robs, 0);
    if (want_mc_idle) check({name, " no_mc"}, mcs, 0);
  endtask

  initial begin
    vecs[0] = '{LW,  32'h0000_0100, 32'h4,         32'h1234_5678, 32'h0000_0104, 2'd2, 32'h1234_5678};
    vecs[1] = '{LB,  32'h0000_0200, 32'h0,         32'hABCD_12F0, 32'h0000_0200, 2'd0, 32'hFFFF_FFF0};
    vecs[2] = '{LBU, 32'h0000_0200, 32'h1,         32'hABCD_12F0, 32'h0000_0201, 2'd0, 32'h0000_00F0};
    vecs[3] = '{LH,  32'h0000_0300, 32'hFFFF_FFFE, 32'h0000_8001, 32'h0000_02FE, 2'd1, 32'hFFFF_8001};
    vecs[4] = '{LHU, 32'h0000_0300, 32'h2,         32'h0000_8001, 32'h0000_0302, 2'd1, 32'h0000_8001};
    vecs[5] = '{LW,  32'hFFFF_FFFC, 32'h8,         32'hDEAD_BEEF, 32'h0000_0004, 2'd2, 32'hDEAD_BEEF};
    vecs[6] = '{LB,  32'h0000_0000, 32'h10,        32'h0000_007F, 32'h0000_0010, 2'd0, 32'h0000_007F};
    vecs[7] = '{LH,  32'h0000_0000, 32'h0,         32'h1234_7FFF, 32'h0000_0000, 2'd1, 32'h0000_7FFF};

    repeat (2) @(negedge clk);
    check("reset mc_en", {31'd0, oMC_en}, 32'd0);
    check("reset rob_en", {31'd0, oROB_en}, 32'd0);
    check("reset full", {31'd0, oFULL}, 32'd0);
    check("reset addr", oMC_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    quiet("empty", 3, 1'b1);

    // Table-driven single loads.
    for (int v = 0; v < 8; v++) begin
      dispatch(vecs[v].op, 5'(v + 1), vecs[v].imm, 5'd0, vecs[v].rs1, 5'd0, 32'd0);
      wait_mc($sformatf("vec%0d", v));
      check($sformatf("vec%0d addr", v), oMC_addr, vecs[v].addr);
      check($sformatf("vec%0d len", v), {30'd0, oMC_len}, {30'd0, vecs[v].len});
      check($sformatf("vec%0d wr", v), {31'd0, oMC_wr}, 32'd0);
      service($sformatf("vec%0d", v), vecs[v].raw, 3, 5'(v + 1), vecs[v].dt);
    end

    // LB then LBU in program order.
    dispatch(LB, 5'd1, 32'h0, 5'd0, 32'h40, 5'd0, 32'd0);
    dispatch(LBU, 5'd2, 32'h0, 5'd0, 32'h41, 5'd0, 32'd0);
    wait_mc("lb");
    check("lb addr", oMC_addr, 32'h40);
    service("lb", 32'h80, 0, 5'd1, 32'hFFFF_FF80);
    wait_mc("lbu");
    check("lbu addr", oMC_addr, 32'h41);
    service("lbu", 32'h80, 0, 5'd2, 32'h0000_0080);

    // Same-cycle capture of rs1 from the ALU CDB.
    iEX_en = 1'b1; iEX_nick = 5'd6; iEX_dt = 32'h500;
    dispatch(LW, 5'd12, 32'h10, 5'd6, 32'h0, 5'd0, 32'd0);
    iEX_en = 1'b0;
    wait_mc("capture");
    check("capture addr", oMC_addr, 32'h510);
    service("capture", 32'h7777, 1, 5'd12, 32'h7777);

    // Wakeup of a waiting load from our own load result.
    dispatch(LW, 5'd10, 32'h0, 5'd0, 32'h700, 5'd0, 32'd0);
    dispatch(LW, 5'd11, 32'h8, 5'd10, 32'h0, 5'd0, 32'd0);
    wait_mc("producer");
    service("producer", 32'h600, 1, 5'd10, 32'h600);
    wait_mc("consumer");
    check("consumer addr", oMC_addr, 32'h608);
    service("consumer", 32'h1, 1, 5'd11, 32'h1);

    // Store waits for rs2 and then for commit.
    dispatch(SW, 5'd7, 32'h0, 5'd0, 32'h40, 5'd5, 32'd0);
    repeat (3) @(negedge clk);
    check("st wait rs2", {31'd0, oMC_en}, 32'd0);
    iEX_en = 1'b1; iEX_nick = 5'd5; iEX_dt = 32'hAB;
    @(negedge clk);
    iEX_en = 1'b0;
    repeat (3) @(negedge clk);
    check("st wait commit", {31'd0, oMC_en}, 32'd0);
    iROB_store_en = 1'b1; iROB_store_nick = 5'd7;
    @(negedge clk);
    iROB_store_en = 1'b0;
    wait_mc("st");
    check("st wr", {31'd0, oMC_wr}, 32'd1);
    check("st dt", oMC_dt, 32'hAB);
    check("st addr", oMC_addr, 32'h40);
    check("st len", {30'd0, oMC_len}, 32'd2);
    service("st", 32'hFFFF_FFFF, 2, 5'd7, 32'd0);

    // Flush while a load is in flight: its completion is discarded.
    dispatch(LW, 5'd20, 32'h0, 5'd0, 32'h90, 5'd0, 32'd0);
    wait_mc("disc");
    iCLR = 1'b1;
    @(negedge clk);
    iCLR = 1'b0;
    check("disc mc held", {31'd0, oMC_en}, 32'd1);
    mc_done(32'h99, 1);
    quiet("disc", 5, 1'b1);
    dispatch(LW, 5'd21, 32'h0, 5'd0, 32'h44, 5'd0, 32'd0);
    wait_mc("after disc");
    check("after disc addr", oMC_addr, 32'h44);
    service("after disc", 32'h5, 0, 5'd21, 32'h5);

    // Committed SB survives a flush; younger loads vanish.
    dispatch(SB, 5'd12, 32'h0, 5'd0, 32'h80, 5'd9, 32'd0);
    dispatch(LW, 5'd13, 32'h0, 5'd0, 32'h84, 5'd0, 32'd0);
    dispatch(LW, 5'd14, 32'h0, 5'd0, 32'h88, 5'd0, 32'd0);
    iROB_store_en = 1'b1; iROB_store_nick = 5'd12;
    @(negedge clk);
    iROB_store_en = 1'b0;
    iCLR = 1'b1;
    @(negedge clk);
    iCLR = 1'b0;
    iEX_en = 1'b1; iEX_nick = 5'd9; iEX_dt = 32'h5A;
    @(negedge clk);
    iEX_en = 1'b0;
    wait_mc("sb");
    check("sb wr", {31'd0, oMC_wr}, 32'd1);
    check("sb addr", oMC_addr, 32'h80);
    check("sb len", {30'd0, oMC_len}, 32'd0);
    check("sb dt", oMC_dt, 32'h5A);
    service("sb", 32'h0, 1, 5'd12, 32'd0);
    quiet("flushed loads", 6, 1'b1);
    dispatch(LW, 5'd15, 32'h0, 5'd0, 32'h8C, 5'd0, 32'd0);
    wait_mc("post flush");
    check("post flush addr", oMC_addr, 32'h8C);
    service("post flush", 32'hCAFE, 0, 5'd15, 32'hCAFE);

    // Fill to DEPTH-1, drain with wrap-around.
    for (int i = 0; i < 15; i++) begin
      dispatch(LW, 5'(i + 1), 32'h0, 5'd0, 32'(i * 16), 5'd0, 32'd0);
      if (i == 13) check("full at 14", {31'd0, oFULL}, 32'd0);
    end
    check("full at 15", {31'd0, oFULL}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      wait_mc($sformatf("fill%0d", i));
      check($sformatf("fill%0d addr", i), oMC_addr, 32'(i * 16));
      service($sformatf("fill%0d", i), 32'h1000 + 32'(i), 0, 5'(i + 1), 32'h1000 + 32'(i));
      if (i == 0) check("full after pop", {31'd0, oFULL}, 32'd0);
    end

    // Asynchronous reset in the middle of WAIT.
    dispatch(LW, 5'd3, 32'h0, 5'd0, 32'h10, 5'd0, 32'd0);
    dispatch(LW, 5'd4, 32'h0, 5'd0, 32'h20, 5'd0, 32'd0);
    wait_mc("pre rst");
    #2 rst = 1'b0;
    #1;
    check("rst mc_en", {31'd0, oMC_en}, 32'd0);
    check("rst mc_wr", {31'd0, oMC_wr}, 32'd0);
    check("rst mc_addr", oMC_addr, 32'd0);
    check("rst mc_len", {30'd0, oMC_len}, 32'd0);
    check("rst mc_dt", oMC_dt, 32'd0);
    check("rst rob_en", {31'd0, oROB_en}, 32'd0);
    check("rst rob_nick", {27'd0, oROB_nick}, 32'd0);
    check("rst full", {31'd0, oFULL}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mc_done(32'h1, 0);
    quiet("stale done", 4, 1'b1);
    dispatch(LW, 5'd8, 32'h4, 5'd0, 32'h30, 5'd0, 32'd0);
    wait_mc("post rst");
    check("post rst addr", oMC_addr, 32'h34);
    service("post rst", 32'h42, 1, 5'd8, 32'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
